mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle data-memory access controller between the `mem` stage and the data RAM. It accepts one load/store per request from `mem`, checks alignment, drives a byte-enabled req/ack RAM transaction, and holds the pipeline stalled until the RAM responds. On completion it returns sign- or zero-extended load data to `mem` for forwarding into `mem_wb`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: RAM word width; fixed at 32 for the byte-lane logic.
- `TIMEOUT_CYCLES`, default 16: maximum number of REQ cycles to wait for `ram_ack_i`; used only with the configuration macro.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_i` in 1: `mem` presents a valid access.
- `op_i` in 4: `LB`/`LH`/`LW`/`LBU`/`LHU`/`SB`/`SH`/`SW`/`NONE` codes from `defines.v`.
- `addr_i` in ADDR_WIDTH: byte address.
- `wdata_i` in 32: store data, right-aligned.
- `rdata_o` out 32: extended load result; valid when `done_o` is high.
- `done_o` out 1: one-cycle pulse marking access complete.
- `err_o` out 1: high together with `done_o` for a misaligned or timed-out access.
- `stall_o` out 1: holds the pipeline (IF through EXE/MEM).
- `ram_req_o` out 1: RAM request.
- `ram_we_o` out 1: RAM write.
- `ram_addr_o` out ADDR_WIDTH: word address, with bits [1:0] forced to 0.
- `ram_be_o` out 4: byte enables.
- `ram_wdata_o` out 32: lane-replicated store data.
- `ram_ack_i` in 1: RAM completion.
- `ram_rdata_i` in 32: read word; valid while `ram_ack_i` is high.

## Operation
- States:
  - **IDLE**: waiting for a request.
  - **REQ**: RAM transaction outstanding.
  - **DONE**: result presented.
- **IDLE**:
  - A request is accepted when `req_i` is high and `op_i` is not `NONE`. `op_i`, `addr_i` and `wdata_i` are latched internally.
  - **Aligned request**: go to REQ.
  - **Misaligned request**: go to DONE with the error flag set; no RAM access is made. Misaligned means `addr_i[0]` = 1 for `LH`/`LHU`/`SH`, or `addr_i[1:0]` ≠ 0 for `LW`/`SW`.
  - When `req_i` is high with `op_i` = `NONE`, nothing is accepted and `stall_o` stays 0.
- **REQ**:
  - `ram_req_o` = 1, together with the registered `ram_we_o`, `ram_addr_o`, `ram_be_o` and `ram_wdata_o`. All of these stay stable until the ack.
  - When `ram_ack_i` is high: capture and extend `ram_rdata_i` (loads), drop `ram_req_o`, go to DONE.
- **DONE**: `done_o` = 1 and `stall_o` = 0 for one cycle, then return to IDLE. `req_i` is ignored in DONE.
- Byte enables and write data:
  - `SB`: `be` = 1 << `addr[1:0]`, `wdata` = {4{`wdata[7:0]`}}.
  - `SH`: `be` = 0011 when `addr[1]` = 0, 1100 when `addr[1]` = 1; `wdata` = {2{`wdata[15:0]`}}.
  - `SW`: `be` = 1111.
  - Loads: `be` = 1111, `ram_we_o` = 0.
- Load extraction:
  - Byte lane is selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - `LB`/`LH` sign-extend; `LBU`/`LHU` zero-extend; `LW` passes the word through.
  - Stores and errored accesses return `rdata_o` = 0.
- `stall_o` = 1 in two cases:
  - combinationally, in IDLE while a valid request is present;
  - throughout REQ.

## Timing
- Reset value of every output is 0. Asserting `rst_n_i` mid-transaction forces IDLE and drops `ram_req_o` immediately. A late `ram_ack_i` after reset or after a timeout is ignored while in IDLE.
- Minimum latency:
  - Ack in the first REQ cycle: 3 cycles, so `done_o` is asserted 2 cycles after request acceptance.
  - Each extra RAM wait cycle adds 1 cycle.
  - Misaligned request: `done_o` on the next cycle, 2-cycle occupancy.
- `ram_ack_i` is only sampled in REQ. An ack on the same edge as entry to REQ is not possible, because `ram_req_o` is registered.
- `rdata_o` and `err_o` hold their values through the DONE cycle only and return to 0 in IDLE.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - A counter, cleared on entry to REQ, increments in each REQ cycle without an ack.
  - When it reaches `TIMEOUT_CYCLES`, drop `ram_req_o` and go to DONE with `err_o` = 1 and `rdata_o` = 0.
  - An ack in the same cycle as the terminal count wins, and no error is raised.
- `MEM_ACCESS_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely for `ram_ack_i`.

## Test plan
- `LB` at addr 0x103, RAM returns 0x80FF_FFFF with ack on the first REQ cycle -> `rdata_o` = 0xFFFF_FF80, `done_o` 2 cycles after acceptance, `stall_o` high for exactly 2 cycles.
- `LHU` at 0x202, ack after 3 wait cycles, RAM data 0x9ABC_1234 -> `rdata_o` = 0x0000_9ABC; `ram_req_o`/`ram_addr_o` = 0x200 held stable for 4 cycles.
- `SB` of 0xA5 at 0x0006 -> `ram_we_o` = 1, `ram_be_o` = 0100, `ram_wdata_o` = 0xA5A5_A5A5, `ram_addr_o` = 0x4; `SH` at 0x6 -> `be` = 1100.
- `LW` at 0x101 -> no `ram_req_o`; the next cycle has `done_o` = 1, `err_o` = 1, `rdata_o` = 0.
- With `MEM_ACCESS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, no ack -> `err_o`/`done_o` after the 16th REQ cycle; a late ack in IDLE causes no output change.
- `rst_n_i` pulsed low during REQ -> all outputs 0 asynchronously; after release, a new `SW` completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Multi-cycle data-memory access controller sitting between the mem stage
//   and the data RAM. Accepts one load/store, checks alignment, runs a single
//   byte-enabled req/ack RAM transaction and stalls the pipeline until the RAM
//   answers. Returns sign/zero-extended load data with a one-cycle done pulse.
//
//   Optional feature macro: MEM_ACCESS_TIMEOUT_EN
//     defined   -> REQ gives up after TIMEOUT_CYCLES ack-less cycles (err_o=1)
//     undefined -> REQ waits for ram_ack_i indefinitely
//
// Ports
//   clk_i, rst_n_i       clock, async active-low reset
//   req_i, op_i          access request from mem and its op code
//   addr_i, wdata_i      byte address, right-aligned store data
//   rdata_o              extended load result (valid with done_o)
//   done_o, err_o        completion pulse, misaligned/timeout flag
//   stall_o              pipeline hold
//   ram_req_o/we_o       RAM request / write strobe
//   ram_addr_o           word address (bits [1:0] = 0)
//   ram_be_o, ram_wdata_o byte enables, lane-replicated store data
//   ram_ack_i, ram_rdata_i RAM completion and read word
module mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic [3:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  stall_o,
  output logic                  ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic                  ram_ack_i,
  input  logic [31:0]           ram_rdata_i
);

  // Op codes (shared with the pipeline's defines)
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]            ram_be_q, ram_be_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Incoming request decode
  logic        valid_req;
  logic        in_store;
  logic        in_bad;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  assign valid_req = req_i && (op_i != OP_NONE);

  always_comb begin
    in_store = 1'b0;
    in_bad   = 1'b0;
    in_be    = 4'b1111;
    in_wdata = wdata_i;
    case (op_i)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: in_bad = addr_i[0];
      OP_LW:         in_bad = |addr_i[1:0];
      OP_SB: begin
        in_store = 1'b1;
        in_be    = 4'b0001 << addr_i[1:0];
        in_wdata = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        in_store = 1'b1;
        in_bad   = addr_i[0];
        in_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{wdata_i[15:0]}};
      end
      OP_SW: begin
        in_store = 1'b1;
        in_bad   = |addr_i[1:0];
      end
      // Undefined op codes are completed with an error rather than
      // touching the RAM with an unknown access type.
      default: in_bad = 1'b1;
    endcase
  end

  // Load lane extraction from the RAM word
  function automatic logic [31:0] load_ext(input logic [3:0]  op,
                                           input logic [1:0]  lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      OP_LW:   load_ext = w;
      default: load_ext = 32'h0;
    endcase
  endfunction

  // Optional REQ timeout
  logic timeout_hit;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  // Terminal count reached on the TIMEOUT_CYCLES-th ack-less REQ cycle
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE)                   cnt_d = '0;
    else if (state_q == S_REQ && !ram_ack_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Parameters only meaningful in some builds
  logic unused_params;
  assign unused_params = (TIMEOUT_CYCLES == 0) | (DATA_WIDTH != 32);

  // Next-state / datapath
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_be_d    = ram_be_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (valid_req) begin
          op_d   = op_i;
          lane_d = addr_i[1:0];
          if (in_bad) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else begin
            ram_req_d   = 1'b1;
            ram_we_d    = in_store;
            ram_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            ram_be_d    = in_be;
            ram_wdata_d = in_store ? in_wdata : 32'h0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack beats the terminal count when both happen together
        if (ram_ack_i || timeout_hit) begin
          rdata_d     = ram_ack_i ? load_ext(op_q, lane_q, ram_rdata_i) : 32'h0;
          err_d       = !ram_ack_i;
          ram_req_d   = 1'b0;
          ram_we_d    = 1'b0;
          ram_addr_d  = '0;
          ram_be_d    = 4'b0000;
          ram_wdata_d = 32'h0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      lane_q      <= 2'b00;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= 4'b0000;
      ram_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_be_q    <= ram_be_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  // Gated by reset so every output reads 0 while reset is held
  assign stall_o     = rst_n_i & (((state_q == S_IDLE) & valid_req) | (state_q == S_REQ));
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_be_o    = ram_be_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        done_o, err_o, stall_o;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic        ram_ack_i;
  logic [31:0] ram_rdata_i;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];

  mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .stall_o(stall_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o),
    .ram_ack_i(ram_ack_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected_done: done_o=1 with no access outstanding");
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (rdata_o !== e.rdata) begin
          fails++;
          $display("FAIL sb_rdata: got %h expected %h", rdata_o, e.rdata);
        end
        tests++;
        if (err_o !== e.err) begin
          fails++;
          $display("FAIL sb_err: got %b expected %b", err_o, e.err);
        end
      end
    end
  end

  // One access: request on one cycle, RAM acks after `waits` extra REQ cycles.
  task automatic access(input string name, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] word,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic exp_we, input logic [31:0] exp_wd);
    int st;
    exp_t e;
    st = 0;
    e.rdata = exp_rd; e.err = exp_err;
    @(negedge clk);
    req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
    sb.push_back(e);
    #1 st += int'(stall_o);
    @(negedge clk);
    req_i = 1'b0; op_i = OP_NONE;
    #1;
    if (exp_err) begin
      tests++;
      if (ram_req_o !== 1'b0 || done_o !== 1'b1) begin
        fails++;
        $display("FAIL %s_misalign: ram_req=%b done=%b expected ram_req=0 done=1", name, ram_req_o, done_o);
      end
      st += int'(stall_o);
      tests++;
      if (st != 1) begin
        fails++;
        $display("FAIL %s_stall: stall cycles %0d expected 1", name, st);
      end
    end else begin
      tests++;
      if (ram_req_o !== 1'b1 || ram_addr_o !== exp_addr || ram_be_o !== exp_be || ram_we_o !== exp_we) begin
        fails++;
        $display("FAIL %s_ram: req=%b addr=%h be=%b we=%b expected 1 %h %b %b",
                 name, ram_req_o, ram_addr_o, ram_be_o, ram_we_o, exp_addr, exp_be, exp_we);
      end
      if (exp_we) begin
        tests++;
        if (ram_wdata_o !== exp_wd) begin
          fails++;
          $display("FAIL %s_wdata: got %h expected %h", name, ram_wdata_o, exp_wd);
        end
      end
      st += int'(stall_o);
      for (int i = 0; i < waits; i++) begin
        @(negedge clk); #1;
        tests++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== exp_addr) begin
          fails++;
          $display("FAIL %s_hold: wait %0d req=%b addr=%h expected 1 %h", name, i, ram_req_o, ram_addr_o, exp_addr);
        end
        st += int'(stall_o);
      end
      ram_ack_i = 1'b1; ram_rdata_i = word;
      @(negedge clk); #1;
      ram_ack_i = 1'b0; ram_rdata_i = $urandom;
      tests++;
      if (done_o !== 1'b1 || ram_req_o !== 1'b0 || stall_o !== 1'b0) begin
        fails++;
        $display("FAIL %s_done: done=%b ram_req=%b stall=%b expected 1 0 0", name, done_o, ram_req_o, stall_o);
      end
      tests++;
      if (st != 2 + waits) begin
        fails++;
        $display("FAIL %s_stall: stall cycles %0d expected %0d", name, st, 2 + waits);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    tests++;
    if ({done_o, err_o, stall_o, ram_req_o, ram_we_o} !== 5'b0 || rdata_o !== 32'h0 ||
        ram_addr_o !== 32'h0 || ram_be_o !== 4'h0 || ram_wdata_o !== 32'h0) begin
      fails++;
      $display("FAIL %s: done=%b err=%b stall=%b req=%b we=%b rdata=%h addr=%h be=%b wd=%h expected all 0",
               name, done_o, err_o, stall_o, ram_req_o, ram_we_o, rdata_o, ram_addr_o, ram_be_o, ram_wdata_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 1'b0; op_i = OP_NONE; addr_i = '0; wdata_i = '0;
    ram_ack_i = 1'b0; ram_rdata_i = '0;
    #12 check_quiet("reset_outputs");
    @(negedge clk); rst_n = 1'b1;
    #1 check_quiet("post_reset_idle");
  endtask

  task automatic test_loads();
    access("lb",  OP_LB,  32'h103, 32'h0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0, 32'h100, 4'hF, 1'b0, 32'h0);
    access("lhu", OP_LHU, 32'h202, 32'h0, 3, 32'h9ABC_1234, 32'h0000_9ABC, 1'b0, 32'h200, 4'hF, 1'b0, 32'h0);
    access("lh",  OP_LH,  32'h000, 32'h0, 1, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 32'h000, 4'hF, 1'b0, 32'h0);
    access("lbu", OP_LBU, 32'h011, 32'h0, 0, 32'h1234_5678, 32'h0000_0056, 1'b0, 32'h010, 4'hF, 1'b0, 32'h0);
    access("lw",  OP_LW,  32'h010, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h010, 4'hF, 1'b0, 32'h0);
    // DONE cycle is over: rdata/err must be back to 0
    @(negedge clk); #1 check_quiet("idle_after_done");
  endtask

  task automatic test_stores();
    access("sb", OP_SB, 32'h006, 32'h0000_00A5, 0, 32'h0, 32'h0, 1'b0, 32'h004, 4'b0100, 1'b1, 32'hA5A5_A5A5);
    access("sh", OP_SH, 32'h006, 32'h0000_BEEF, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h004, 4'b1100, 1'b1, 32'hBEEF_BEEF);
    access("sh0", OP_SH, 32'h008, 32'h0000_1234, 0, 32'h0, 32'h0, 1'b0, 32'h008, 4'b0011, 1'b1, 32'h1234_1234);
  endtask

  task automatic test_misaligned();
    access("lw_mis", OP_LW, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0);
    // Request presented during DONE must be ignored
    req_i = 1'b1; op_i = OP_LW; addr_i = 32'h40;
    @(negedge clk);
    req_i = 1'b0; op_i = OP_NONE;
    #1;
    tests++;
    if (stall_o !== 1'b0 || ram_req_o !== 1'b0) begin
      fails++;
      $display("FAIL done_ignores_req: stall=%b ram_req=%b expected 0 0", stall_o, ram_req_o);
    end
    access("sh_mis", OP_SH, 32'h003, 32'h0, 0, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic test_none();
    @(negedge clk);
    req_i = 1'b1; op_i = OP_NONE; addr_i = 32'h20;
    #1;
    tests++;
    if (stall_o !== 1'b0) begin
      fails++;
      $display("FAIL none_stall: stall=%b expected 0", stall_o);
    end
    @(negedge clk); req_i = 1'b0;
    #1 check_quiet("none_not_accepted");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_i = 1'b1; op_i = OP_LW; addr_i = 32'h30;
    @(negedge clk);
    req_i = 1'b0; op_i = OP_NONE;
    #1;
    tests++;
    if (ram_req_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: ram_req=%b expected 1", ram_req_o);
    end
    #2 rst_n = 1'b0;
    #1 check_quiet("rst_mid_async");
    @(negedge clk); rst_n = 1'b1;
    // Late ack arriving in IDLE must be ignored
    ram_ack_i = 1'b1; ram_rdata_i = 32'hCAFE_F00D;
    @(negedge clk); ram_ack_i = 1'b0;
    #1 check_quiet("late_ack_idle");
    access("sw_after_rst", OP_SW, 32'h020, 32'h1122_3344, 1, 32'h0, 32'h0, 1'b0, 32'h020, 4'hF, 1'b1, 32'h1122_3344);
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    e.rdata = 32'h0; e.err = 1'b1;
    @(negedge clk);
    req_i = 1'b1; op_i = OP_LW; addr_i = 32'h40;
    sb.push_back(e);
    @(negedge clk);
    req_i = 1'b0; op_i = OP_NONE;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      tests++;
      if (ram_req_o !== 1'b1 || done_o !== 1'b0) begin
        fails++;
        $display("FAIL timeout_req: cycle %0d ram_req=%b done=%b expected 1 0", i, ram_req_o, done_o);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (done_o !== 1'b1 || err_o !== 1'b1 || ram_req_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_done: done=%b err=%b ram_req=%b expected 1 1 0", done_o, err_o, ram_req_o);
    end
    @(negedge clk);
    ram_ack_i = 1'b1; ram_rdata_i = 32'h1234_5678;
    @(negedge clk); ram_ack_i = 1'b0;
    #1 check_quiet("timeout_late_ack");
  endtask
`else
  task automatic test_long_wait();
    access("lw_long", OP_LW, 32'h044, 32'h0, 20, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 32'h044, 4'hF, 1'b0, 32'h0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_none();
    test_reset_mid();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    @(negedge clk); @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
